// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: FSM states, widths and the op_sub encoding.
package calc_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned CALC_WIDTH = 64;
  localparam int unsigned CLA_SLICE  = 8;
  localparam int unsigned NUM_SLICES = CALC_WIDTH / CLA_SLICE;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/carry_look_ahead_adder_8.sv
// 8-bit carry look-ahead adder built from generate/propagate terms.
module carry_look_ahead_adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum   = p ^ c[7:0];
    c_out = c[8];
  end
endmodule

// File: rtl/cla64_sequencer.sv
// Multi-cycle add/subtract: one 8-bit CLA reused across all slices, LSB slice first,
// with the inter-slice carry registered between cycles.
module cla64_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH,
  parameter int unsigned SLICE = CLA_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);
  localparam int unsigned NSL   = WIDTH / SLICE;
  localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             c_sl;
  logic             last;

  assign a_sl = a_q[idx*SLICE +: SLICE];
  assign b_sl = b_q[idx*SLICE +: SLICE];
  assign last = (idx == IDX_W'(NSL - 1));
  assign busy = (state == RUN);

  carry_look_ahead_adder_8 u_cla (
    .a     (a_sl),
    .b     (b_sl),
    .c_in  (carry_q),
    .sum   (sum_sl),
    .c_out (c_sl)
  );

  // Merge the current slice so the final cycle can publish the full sum directly.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[idx*SLICE +: SLICE] = sum_sl;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= (op_sub == OP_SUB) ? ~b : b;
            carry_q <= op_sub;
            idx     <= '0;
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          carry_q <= c_sl;
          if (last) begin
            result   <= acc_nxt;
            c_out    <= c_sl;
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_sl[SLICE-1] != a_q[WIDTH-1]);
            done     <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
